// File: rtl/fp_execute_stage2_if.sv
// Shared FP pipeline types and the stage-1 to stage-2 bundle interface.
// The master side drives the fx1_* bundle and observes the fx2_* result.
package fp_pkg;
    localparam int VECTOR_LANES = 16;
    localparam int THREAD_IDX_W = 2;
    localparam int SUBCYCLE_W = 4;

    typedef logic [THREAD_IDX_W-1:0] thread_idx_t;
    typedef logic [SUBCYCLE_W-1:0] subcycle_t;

    typedef enum logic [5:0] {
        OP_MULL_I = 6'h07,
        OP_MULH_I = 6'h08,
        OP_FTOI   = 6'h1b,
        OP_MULH_U = 6'h1f,
        OP_ADD_F  = 6'h20,
        OP_SUB_F  = 6'h21,
        OP_MUL_F  = 6'h22
    } alu_op_t;

    typedef struct packed {
        alu_op_t     alu_op;
        logic [4:0]  dest_reg;
        logic        dest_is_vector;
        logic        has_dest;
        logic [31:0] pc;
    } decoded_instruction_t;
endpackage

interface fp_execute_stage2_if
    import fp_pkg::*;
#(
    parameter int NUM_LANES = VECTOR_LANES
);
    logic                              fx1_instruction_valid;
    decoded_instruction_t              fx1_instruction;
    logic [NUM_LANES-1:0]              fx1_mask_value;
    thread_idx_t                       fx1_thread_idx;
    subcycle_t                         fx1_subcycle;
    logic [NUM_LANES-1:0]              fx1_result_is_inf;
    logic [NUM_LANES-1:0]              fx1_result_is_nan;
    logic [NUM_LANES-1:0][31:0]        fx1_significand_le;
    logic [NUM_LANES-1:0][31:0]        fx1_significand_se;
    logic [NUM_LANES-1:0][5:0]         fx1_se_align_shift;
    logic [NUM_LANES-1:0][5:0]         fx1_ftoi_lshift;
    logic [NUM_LANES-1:0][7:0]         fx1_add_exponent;
    logic [NUM_LANES-1:0]              fx1_logical_subtract;
    logic [NUM_LANES-1:0]              fx1_add_result_sign;
    logic [NUM_LANES-1:0][31:0]        fx1_multiplicand;
    logic [NUM_LANES-1:0][31:0]        fx1_multiplier;
    logic [NUM_LANES-1:0][7:0]         fx1_mul_exponent;
    logic [NUM_LANES-1:0]              fx1_mul_sign;

    logic                              fx2_instruction_valid;
    decoded_instruction_t              fx2_instruction;
    logic [NUM_LANES-1:0]              fx2_mask_value;
    thread_idx_t                       fx2_thread_idx;
    subcycle_t                         fx2_subcycle;
    logic [NUM_LANES-1:0]              fx2_result_is_inf;
    logic [NUM_LANES-1:0]              fx2_result_is_nan;
    logic [NUM_LANES-1:0][31:0]        fx2_significand_le;
    logic [NUM_LANES-1:0][31:0]        fx2_significand_se;
    logic [NUM_LANES-1:0]              fx2_guard;
    logic [NUM_LANES-1:0]              fx2_round;
    logic [NUM_LANES-1:0]              fx2_sticky;
    logic [NUM_LANES-1:0][7:0]         fx2_add_exponent;
    logic [NUM_LANES-1:0]              fx2_logical_subtract;
    logic [NUM_LANES-1:0]              fx2_add_result_sign;
    logic [NUM_LANES-1:0][63:0]        fx2_significand_product;
    logic [NUM_LANES-1:0][7:0]         fx2_mul_exponent;
    logic [NUM_LANES-1:0]              fx2_mul_sign;

    modport master (
        output fx1_instruction_valid, fx1_instruction, fx1_mask_value,
               fx1_thread_idx, fx1_subcycle, fx1_result_is_inf,
               fx1_result_is_nan, fx1_significand_le, fx1_significand_se,
               fx1_se_align_shift, fx1_ftoi_lshift, fx1_add_exponent,
               fx1_logical_subtract, fx1_add_result_sign,
               fx1_multiplicand, fx1_multiplier, fx1_mul_exponent,
               fx1_mul_sign,
        input  fx2_instruction_valid, fx2_instruction, fx2_mask_value,
               fx2_thread_idx, fx2_subcycle, fx2_result_is_inf,
               fx2_result_is_nan, fx2_significand_le, fx2_significand_se,
               fx2_guard, fx2_round, fx2_sticky, fx2_add_exponent,
               fx2_logical_subtract, fx2_add_result_sign,
               fx2_significand_product, fx2_mul_exponent, fx2_mul_sign
    );

    modport slave (
        input  fx1_instruction_valid, fx1_instruction, fx1_mask_value,
               fx1_thread_idx, fx1_subcycle, fx1_result_is_inf,
               fx1_result_is_nan, fx1_significand_le, fx1_significand_se,
               fx1_se_align_shift, fx1_ftoi_lshift, fx1_add_exponent,
               fx1_logical_subtract, fx1_add_result_sign,
               fx1_multiplicand, fx1_multiplier, fx1_mul_exponent,
               fx1_mul_sign,
        output fx2_instruction_valid, fx2_instruction, fx2_mask_value,
               fx2_thread_idx, fx2_subcycle, fx2_result_is_inf,
               fx2_result_is_nan, fx2_significand_le, fx2_significand_se,
               fx2_guard, fx2_round, fx2_sticky, fx2_add_exponent,
               fx2_logical_subtract, fx2_add_result_sign,
               fx2_significand_product, fx2_mul_exponent, fx2_mul_sign
    );
endinterface

// File: rtl/fp_execute_stage2.sv
// FP pipeline stage 2: significand alignment with guard/round/sticky,
// float-to-int left shift, and the full 32x32 product per lane.
module fp_execute_stage2
    import fp_pkg::*;
#(
    parameter int NUM_LANES = VECTOR_LANES
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wb_rollback_en,
    input  thread_idx_t  wb_rollback_thread_idx,
    fp_execute_stage2_if.slave fx
);
    logic [NUM_LANES-1:0][63:0] align_ext;
    logic [NUM_LANES-1:0][31:0] se_next;
    logic [NUM_LANES-1:0][63:0] product_next;
    logic                       is_ftoi;
    logic                       is_signed_mul;
    logic                       squash;

    assign is_ftoi = fx.fx1_instruction.alu_op == OP_FTOI;
    assign is_signed_mul = fx.fx1_instruction.alu_op == OP_MULH_I;
    assign squash = wb_rollback_en
        && wb_rollback_thread_idx == fx.fx1_thread_idx;

    // Align the smaller significand; the low word keeps the bits shifted out
    always_comb begin
        align_ext = '0;
        se_next = '0;
        product_next = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            align_ext[i] = {fx.fx1_significand_se[i], 32'd0}
                >> ((fx.fx1_se_align_shift[i] > 6'd32)
                    ? 6'd32 : fx.fx1_se_align_shift[i]);
            if (is_ftoi)
                se_next[i] = align_ext[i][63:32]
                    << fx.fx1_ftoi_lshift[i];
            else
                se_next[i] = align_ext[i][63:32];
            if (is_signed_mul)
                product_next[i] =
                    {{32{fx.fx1_multiplicand[i][31]}},
                     fx.fx1_multiplicand[i]}
                    * {{32{fx.fx1_multiplier[i][31]}},
                       fx.fx1_multiplier[i]};
            else
                product_next[i] = {32'd0, fx.fx1_multiplicand[i]}
                    * {32'd0, fx.fx1_multiplier[i]};
        end
    end

    // Stage register; valid is killed when its thread is rolled back
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fx.fx2_instruction_valid <= 1'b0;
            fx.fx2_instruction <= '0;
            fx.fx2_mask_value <= '0;
            fx.fx2_thread_idx <= '0;
            fx.fx2_subcycle <= '0;
            fx.fx2_result_is_inf <= '0;
            fx.fx2_result_is_nan <= '0;
            fx.fx2_significand_le <= '0;
            fx.fx2_significand_se <= '0;
            fx.fx2_guard <= '0;
            fx.fx2_round <= '0;
            fx.fx2_sticky <= '0;
            fx.fx2_add_exponent <= '0;
            fx.fx2_logical_subtract <= '0;
            fx.fx2_add_result_sign <= '0;
            fx.fx2_significand_product <= '0;
            fx.fx2_mul_exponent <= '0;
            fx.fx2_mul_sign <= '0;
        end else begin
            fx.fx2_instruction_valid <= fx.fx1_instruction_valid && !squash;
            fx.fx2_instruction <= fx.fx1_instruction;
            fx.fx2_mask_value <= fx.fx1_mask_value;
            fx.fx2_thread_idx <= fx.fx1_thread_idx;
            fx.fx2_subcycle <= fx.fx1_subcycle;
            fx.fx2_result_is_inf <= fx.fx1_result_is_inf;
            fx.fx2_result_is_nan <= fx.fx1_result_is_nan;
            fx.fx2_significand_le <= fx.fx1_significand_le;
            fx.fx2_significand_se <= se_next;
            for (int i = 0; i < NUM_LANES; i++) begin
                fx.fx2_guard[i] <= align_ext[i][31];
                fx.fx2_round[i] <= align_ext[i][30];
                fx.fx2_sticky[i] <= |align_ext[i][29:0];
            end
            fx.fx2_add_exponent <= fx.fx1_add_exponent;
            fx.fx2_logical_subtract <= fx.fx1_logical_subtract;
            fx.fx2_add_result_sign <= fx.fx1_add_result_sign;
            fx.fx2_significand_product <= product_next;
            fx.fx2_mul_exponent <= fx.fx1_mul_exponent;
            fx.fx2_mul_sign <= fx.fx1_mul_sign;
        end
    end
endmodule

// File: tb/tb_fp_execute_stage2.sv
// Bench for fp_execute_stage2: vector table through a scoreboard queue,
// plus hand-written reset sequences.
module tb_fp_execute_stage2;
    import fp_pkg::*;

    localparam int LANES = VECTOR_LANES;

    typedef struct {
        logic        valid;
        logic        rb_en;
        thread_idx_t rb_thr;
        thread_idx_t thr;
        alu_op_t     op;
        logic [31:0] se;
        logic [5:0]  s;
        logic [5:0]  lsh;
        logic [31:0] a;
        logic [31:0] b;
        logic        ev;
        logic [31:0] ese;
        logic        eg;
        logic        er;
        logic        est;
        logic [63:0] eprod;
    } vec_t;

    typedef struct {
        vec_t v;
        int   idx;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_rollback_en = 1'b0;
    thread_idx_t wb_rollback_thread_idx = '0;

    int n_checks = 0;
    int n_pass = 0;

    vec_t tbl[14];
    sb_t  sb[$];
    sb_t  e;

    fp_execute_stage2_if #(.NUM_LANES(LANES)) bus();

    fp_execute_stage2 #(.NUM_LANES(LANES)) dut (
        .clk(clk),
        .reset(reset),
        .wb_rollback_en(wb_rollback_en),
        .wb_rollback_thread_idx(wb_rollback_thread_idx),
        .fx(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(vec_t v, int idx);
        wb_rollback_en = v.rb_en;
        wb_rollback_thread_idx = v.rb_thr;
        bus.fx1_instruction_valid = v.valid;
        bus.fx1_instruction = '0;
        bus.fx1_instruction.alu_op = v.op;
        bus.fx1_instruction.pc = 32'h1000 + 32'(idx * 4);
        bus.fx1_mask_value = LANES'(16'ha5a5 ^ idx);
        bus.fx1_thread_idx = v.thr;
        bus.fx1_subcycle = subcycle_t'(idx);
        for (int i = 0; i < LANES; i++) begin
            bus.fx1_result_is_inf[i] = i[0];
            bus.fx1_result_is_nan[i] = ~i[0];
            bus.fx1_significand_le[i] = 32'h1234_0000 | 32'(i);
            bus.fx1_significand_se[i] = v.se;
            bus.fx1_se_align_shift[i] = v.s;
            bus.fx1_ftoi_lshift[i] = v.lsh;
            bus.fx1_add_exponent[i] = 8'(8'h10 + i);
            bus.fx1_logical_subtract[i] = i[1];
            bus.fx1_add_result_sign[i] = i[2];
            bus.fx1_multiplicand[i] = v.a;
            bus.fx1_multiplier[i] = v.b;
            bus.fx1_mul_exponent[i] = 8'(8'h80 - i);
            bus.fx1_mul_sign[i] = i[0] ^ i[1];
        end
    endtask

    // Scoreboard: each pushed entry is checked one edge after it was driven
    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk($sformatf("valid[%0d]", e.idx),
                bus.fx2_instruction_valid, e.v.ev);
            chk($sformatf("thread[%0d]", e.idx),
                bus.fx2_thread_idx, e.v.thr);
            chk($sformatf("alu_op[%0d]", e.idx),
                bus.fx2_instruction.alu_op, e.v.op);
            chk($sformatf("pc[%0d]", e.idx), bus.fx2_instruction.pc,
                32'h1000 + 32'(e.idx * 4));
            chk($sformatf("mask[%0d]", e.idx), bus.fx2_mask_value,
                LANES'(16'ha5a5 ^ e.idx));
            chk($sformatf("subcyc[%0d]", e.idx), bus.fx2_subcycle,
                subcycle_t'(e.idx));
            for (int i = 0; i < LANES; i++) begin
                chk($sformatf("se[%0d][%0d]", e.idx, i),
                    bus.fx2_significand_se[i], e.v.ese);
                chk($sformatf("grs[%0d][%0d]", e.idx, i),
                    {bus.fx2_guard[i], bus.fx2_round[i], bus.fx2_sticky[i]},
                    {e.v.eg, e.v.er, e.v.est});
                chk($sformatf("prod[%0d][%0d]", e.idx, i),
                    bus.fx2_significand_product[i], e.v.eprod);
                chk($sformatf("le[%0d][%0d]", e.idx, i),
                    bus.fx2_significand_le[i], 32'h1234_0000 | 32'(i));
                chk($sformatf("flags[%0d][%0d]", e.idx, i),
                    {bus.fx2_result_is_inf[i], bus.fx2_result_is_nan[i],
                     bus.fx2_logical_subtract[i],
                     bus.fx2_add_result_sign[i], bus.fx2_mul_sign[i]},
                    {i[0], ~i[0], i[1], i[2], i[0] ^ i[1]});
                chk($sformatf("exps[%0d][%0d]", e.idx, i),
                    {bus.fx2_add_exponent[i], bus.fx2_mul_exponent[i]},
                    {8'(8'h10 + i), 8'(8'h80 - i)});
            end
        end
    end

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 2'd0, 2'd0, OP_ADD_F, 32'h00C00001,
                    6'd2, 6'd0, 32'd3, 32'd5,
                    1'b1, 32'h00300000, 1'b0, 1'b1, 1'b0, 64'd15};
        tbl[1]  = '{1'b1, 1'b0, 2'd0, 2'd1, OP_MULH_U, 32'h00FFFFFF,
                    6'd27, 6'd0, 32'hFFFFFFFF, 32'd2,
                    1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 64'h1_FFFFFFFE};
        tbl[2]  = '{1'b1, 1'b0, 2'd0, 2'd2, OP_MULH_I, 32'h00800000,
                    6'd0, 6'd0, 32'hFFFFFFFF, 32'd2,
                    1'b1, 32'h00800000, 1'b0, 1'b0, 1'b0,
                    64'hFFFFFFFF_FFFFFFFE};
        tbl[3]  = '{1'b1, 1'b0, 2'd0, 2'd3, OP_MULL_I, 32'h00800000,
                    6'd32, 6'd0, 32'h80000000, 32'h80000000,
                    1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 64'h40000000_00000000};
        tbl[4]  = '{1'b1, 1'b0, 2'd0, 2'd0, OP_MULH_I, 32'h7FFFFFFF,
                    6'd32, 6'd0, 32'h80000000, 32'd3,
                    1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 64'hFFFFFFFE_80000000};
        tbl[5]  = '{1'b1, 1'b0, 2'd0, 2'd1, OP_FTOI, 32'h00800000,
                    6'd0, 6'd7, 32'd0, 32'd0,
                    1'b1, 32'h40000000, 1'b0, 1'b0, 1'b0, 64'd0};
        tbl[6]  = '{1'b1, 1'b0, 2'd0, 2'd1, OP_FTOI, 32'h0000FFFF,
                    6'd4, 6'd8, 32'h00010000, 32'h00010000,
                    1'b1, 32'h000FFF00, 1'b1, 1'b1, 1'b1, 64'h1_00000000};
        tbl[7]  = '{1'b1, 1'b0, 2'd0, 2'd2, OP_MUL_F, 32'h00000003,
                    6'd1, 6'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                    1'b1, 32'h1, 1'b1, 1'b0, 1'b0, 64'hFFFFFFFE_00000001};
        tbl[8]  = '{1'b1, 1'b1, 2'd2, 2'd2, OP_SUB_F, 32'h80000000,
                    6'd31, 6'd0, 32'd7, 32'd6,
                    1'b0, 32'h1, 1'b0, 1'b0, 1'b0, 64'd42};
        tbl[9]  = '{1'b1, 1'b1, 2'd1, 2'd2, OP_ADD_F, 32'h0000000C,
                    6'd3, 6'd0, 32'd9, 32'd9,
                    1'b1, 32'h1, 1'b1, 1'b0, 1'b0, 64'd81};
        tbl[10] = '{1'b1, 1'b0, 2'd0, 2'd1, OP_ADD_F, 32'h00C00001,
                    6'd2, 6'd0, 32'd1, 32'd1,
                    1'b1, 32'h00300000, 1'b0, 1'b1, 1'b0, 64'd1};
        tbl[11] = '{1'b1, 1'b1, 2'd3, 2'd3, OP_ADD_F, 32'h00C00001,
                    6'd2, 6'd0, 32'd2, 32'd2,
                    1'b0, 32'h00300000, 1'b0, 1'b1, 1'b0, 64'd4};
        tbl[12] = '{1'b1, 1'b0, 2'd3, 2'd0, OP_ADD_F, 32'h00C00001,
                    6'd2, 6'd0, 32'd3, 32'd3,
                    1'b1, 32'h00300000, 1'b0, 1'b1, 1'b0, 64'd9};
        tbl[13] = '{1'b0, 1'b0, 2'd0, 2'd0, OP_ADD_F, 32'h00C00001,
                    6'd2, 6'd0, 32'd3, 32'd3,
                    1'b0, 32'h00300000, 1'b0, 1'b1, 1'b0, 64'd9};

        // Reset held with valid, non-zero input: outputs stay cleared
        drive(tbl[0], 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", bus.fx2_instruction_valid, 1'b0);
        chk("rst_se", bus.fx2_significand_se[0], 32'h0);
        chk("rst_le", bus.fx2_significand_le[0], 32'h0);
        chk("rst_prod", bus.fx2_significand_product[0], 64'h0);
        chk("rst_mask", bus.fx2_mask_value, '0);
        chk("rst_grs", {bus.fx2_guard, bus.fx2_round, bus.fx2_sticky}, '0);
        chk("rst_exp", bus.fx2_add_exponent[1], 8'h0);

        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            drive(tbl[k], k);
            sb.push_back('{v: tbl[k], idx: k});
        end

        for (int t = 0; t < 10 && sb.size() != 0; t++) @(negedge clk);
        if (sb.size() != 0) begin
            chk("sb_drain", 64'(sb.size()), 64'd0);
            sb.delete();
        end

        // Reset arriving mid-cycle clears valid without waiting for an edge
        @(negedge clk);
        drive(tbl[0], 0);
        @(posedge clk);
        #1;
        chk("mid_pre", bus.fx2_instruction_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("mid_async", bus.fx2_instruction_valid, 1'b0);
        chk("mid_async_se", bus.fx2_significand_se[0], 32'h0);
        @(negedge clk);
        reset = 1'b0;
        bus.fx1_instruction_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_idle", bus.fx2_instruction_valid, 1'b0);
        @(negedge clk);
        bus.fx1_instruction_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_first", bus.fx2_instruction_valid, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
